// File: rtl/vedic_mul_seq_ctrl.sv
// vedic_mul_seq_ctrl: 2*HALF_W x 2*HALF_W unsigned multiply by issuing four partial
// products to one shared HALF_W x HALF_W core and shift-accumulating the results.
// Define VEDIC_SEQ_ZSKIP_EN to skip partials whose selected operand half is zero.
module vedic_mul_seq_ctrl #(
    parameter int HALF_W  = 16,
    parameter int MUL_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2*HALF_W-1:0]   A,
    input  logic [2*HALF_W-1:0]   B,
    output logic                  busy,
    output logic                  done,
    output logic [4*HALF_W-1:0]   P,
    output logic [HALF_W-1:0]     mul_a,
    output logic [HALF_W-1:0]     mul_b,
    input  logic [2*HALF_W-1:0]   mul_p
);
    localparam int FW = 2 * HALF_W;
    localparam int AW = 4 * HALF_W;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state_q, state_d;
    logic [FW-1:0]     opa_q, opa_d, opb_q, opb_d;
    logic [AW-1:0]     acc_q, acc_d, p_q, p_d;
    logic [1:0]        k_q, k_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [HALF_W-1:0] sel_a, sel_b;
    logic [AW-1:0]     part;
    logic              skip;

    // k[0] picks the high half of A, k[1] the high half of B; shift is the sum of both.
    assign sel_a = k_q[0] ? opa_q[FW-1:HALF_W] : opa_q[HALF_W-1:0];
    assign sel_b = k_q[1] ? opb_q[FW-1:HALF_W] : opb_q[HALF_W-1:0];
    assign part  = AW'(mul_p) << (HALF_W * (int'(k_q[0]) + int'(k_q[1])));
`ifdef VEDIC_SEQ_ZSKIP_EN
    assign skip  = (cnt_q == 3'd0) && ((sel_a == '0) || (sel_b == '0));
`else
    assign skip  = 1'b0;
`endif
    assign busy  = (state_q != IDLE);
    assign done  = (state_q == DONE);
    assign P     = p_q;

    // Next-state: accept in IDLE, step partials in RUN, one-cycle DONE pulse.
    always_comb begin
        state_d = state_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        p_d     = p_q;
        k_d     = k_q;
        cnt_d   = cnt_q;
        mul_a   = '0;
        mul_b   = '0;
        case (state_q)
            IDLE: if (start) begin
                opa_d   = A;
                opb_d   = B;
                acc_d   = '0;
                k_d     = '0;
                cnt_d   = '0;
                state_d = RUN;
            end
            RUN: if (skip) begin
                k_d = k_q + 2'd1;
                if (k_q == 2'd3) begin
                    p_d     = acc_q;
                    state_d = DONE;
                end
            end else begin
                mul_a = sel_a;
                mul_b = sel_b;
                if (cnt_q != 3'(MUL_LAT)) cnt_d = cnt_q + 3'd1;
                else begin
                    cnt_d = '0;
                    k_d   = k_q + 2'd1;
                    acc_d = acc_q + part;
                    if (k_q == 2'd3) begin
                        p_d     = acc_d;
                        state_d = DONE;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            p_q     <= '0;
            k_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            p_q     <= p_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_vedic_mul_seq_ctrl.sv
// tb_vedic_mul_seq_ctrl: directed checks of the sequencer at MUL_LAT 1, 0 and 3.
module tb_vedic_mul_seq_ctrl;
`ifdef VEDIC_SEQ_ZSKIP_EN
    localparam int C35 = 6, CFULL = 9, CBB = 6, BBSP = 7, CZERO = 5;
`else
    localparam int C35 = 9, CFULL = 9, CBB = 9, BBSP = 10, CZERO = 9;
`endif
    logic        clk, rst, start, st0, st3;
    logic [31:0] a, b;
    logic        busy1, done1, busy0, done0, busy3, done3;
    logic [63:0] p1, p0, p3;
    logic [15:0] ma1, mb1, ma0, mb0, ma3, mb3;
    logic [31:0] mp1, mp0, mp3, pipe3a, pipe3b;
    logic [15:0] ha [0:63];
    logic [15:0] hb [0:63];
    int          nvec, nerr, bcnt;

    vedic_mul_seq_ctrl #(.HALF_W(16), .MUL_LAT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .A(a), .B(b), .busy(busy1), .done(done1),
        .P(p1), .mul_a(ma1), .mul_b(mb1), .mul_p(mp1));
    vedic_mul_seq_ctrl #(.HALF_W(16), .MUL_LAT(0)) dut0 (
        .clk(clk), .rst(rst), .start(st0), .A(a), .B(b), .busy(busy0), .done(done0),
        .P(p0), .mul_a(ma0), .mul_b(mb0), .mul_p(mp0));
    vedic_mul_seq_ctrl #(.HALF_W(16), .MUL_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(st3), .A(a), .B(b), .busy(busy3), .done(done3),
        .P(p3), .mul_a(ma3), .mul_b(mb3), .mul_p(mp3));

    assign mp0 = 32'(ma0) * 32'(mb0);

    always_ff @(posedge clk) begin
        mp1    <= 32'(ma1) * 32'(mb1);
        pipe3a <= 32'(ma3) * 32'(mb3);
        pipe3b <= pipe3a;
        mp3    <= pipe3b;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] a0, input logic [31:0] b0, input logic [63:0] pmask,
                          input logic [31:0] pa, input logic [31:0] pb, output int cyc);
        @(negedge clk);
        a = a0; b = b0; start = 1'b1;
        cyc = 0; bcnt = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            ha[n] = ma1; hb[n] = mb1;
            if (busy1) bcnt++;
            start = pmask[n];
            if (pmask[n]) begin a = pa; b = pb; end
            if (done1) begin cyc = n; break; end
        end
        @(negedge clk);
        start = 1'b0;
        chk("busy low after done", 64'(busy1), 64'd0);
    endtask

    initial begin
        int cyc, c0, c3, first, second;
        nvec = 0; nerr = 0;
        rst = 1'b1; start = 1'b0; st0 = 1'b0; st3 = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        chk("reset busy", 64'(busy1), 64'd0);
        chk("reset done", 64'(done1), 64'd0);
        chk("reset P", p1, 64'd0);
        chk("reset mul_a", 64'(ma1), 64'd0);
        chk("reset mul_b", 64'(mb1), 64'd0);
        rst = 1'b0;

        run_op(32'h3, 32'h5, 64'h0, 32'h0, 32'h0, cyc);
        chk("3x5 P", p1, 64'hF);
        chk("3x5 done cycle", 64'(cyc), 64'(C35));
        chk("3x5 busy cycles", 64'(bcnt), 64'(C35));
`ifdef VEDIC_SEQ_ZSKIP_EN
        for (int n = 1; n <= 5; n++) begin
            chk("3x5 mul_a seq", 64'(ha[n]), (n <= 2) ? 64'd3 : 64'd0);
            chk("3x5 mul_b seq", 64'(hb[n]), (n <= 2) ? 64'd5 : 64'd0);
        end
`else
        for (int n = 1; n <= 8; n++) begin
            chk("3x5 mul_a seq", 64'(ha[n]), (((n - 1) / 2) % 2 == 1) ? 64'd0 : 64'd3);
            chk("3x5 mul_b seq", 64'(hb[n]), ((n - 1) / 2 >= 2) ? 64'd0 : 64'd5);
        end
`endif

        @(negedge clk);
        a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; st0 = 1'b1; st3 = 1'b1;
        c0 = 0; c3 = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (n == 1) begin st0 = 1'b0; st3 = 1'b0; end
            if (done0 && c0 == 0) c0 = n;
            if (done3 && c3 == 0) c3 = n;
        end
        chk("lat0 P all-ones", p0, 64'hFFFFFFFE00000001);
        chk("lat0 done cycle", 64'(c0), 64'd5);
        chk("lat3 P all-ones", p3, 64'hFFFFFFFE00000001);
        chk("lat3 done cycle", 64'(c3), 64'd17);

        run_op(32'h12345678, 32'h9ABCDEF0, 64'h208, 32'h1, 32'h1, cyc);
        chk("ignored start P", p1, 64'h0B00EA4E242D2080);
        chk("ignored start done cycle", 64'(cyc), 64'(CFULL));

        @(negedge clk);
        a = 32'h00010000; b = 32'h00010000; start = 1'b1;
        first = 0; second = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (done1) begin
                chk("back-to-back P", p1, 64'h0000000100000000);
                if (first == 0) first = n;
                else begin second = n; break; end
            end
        end
        start = 1'b0;
        chk("back-to-back first done", 64'(first), 64'(CBB));
        chk("back-to-back spacing", 64'(second - first), 64'(BBSP));
        @(negedge clk);

        @(negedge clk);
        a = 32'h3; b = 32'h5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid reset busy", 64'(busy1), 64'd0);
        chk("mid reset done", 64'(done1), 64'd0);
        chk("mid reset P", p1, 64'd0);
        chk("mid reset mul_a", 64'(ma1), 64'd0);
        chk("mid reset mul_b", 64'(mb1), 64'd0);
        run_op(32'h3, 32'h5, 64'h0, 32'h0, 32'h0, cyc);
        chk("after reset P", p1, 64'hF);
        chk("after reset done cycle", 64'(cyc), 64'(C35));

        run_op(32'h0, 32'h0, 64'h0, 32'h0, 32'h0, cyc);
        chk("zero P", p1, 64'd0);
        chk("zero done cycle", 64'(cyc), 64'(CZERO));

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/vedic_mul_seq_ctrl.md
Name: vedic_mul_seq_ctrl

Overview:
- Sequencer that computes a 2*HALF_W x 2*HALF_W unsigned product by time-sharing one external HALF_W x HALF_W Vedic multiplier core.
- Issues the four partial products in order, waits the core's latency for each, then shift-accumulates into a 4*HALF_W result.
- Sits between the top-level operand/result interface and a shared 16x16 Vedic core built from the ha/fa cells.

Parameters:
- HALF_W, 16, width of the shared core operands; full operands are 2*HALF_W.
- MUL_LAT, 1, cycles from stable mul_a/mul_b to valid mul_p (0 = combinational core). Legal range 0..7.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request; sampled only when busy=0
- A  input  2*HALF_W  multiplicand, latched when start is accepted
- B  input  2*HALF_W  multiplier, latched when start is accepted
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; P valid
- P  output  4*HALF_W  registered product; holds until the next done
- mul_a  output  HALF_W  operand to the shared core
- mul_b  output  HALF_W  operand to the shared core
- mul_p  input  2*HALF_W  product from the shared core

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, k=0, cnt=0, acc=0, P=0, done=0, busy=0. mul_a=mul_b=0.
- rst overrides everything, including mid-operation. No partial result is written to P. P returns to 0.
- States are IDLE, RUN, DONE.
- IDLE:
  - start=1 latches A and B into opA and opB, clears acc, sets k=0 and cnt=0, and moves to RUN.
  - mul_a and mul_b are 0.
- RUN: partial index k selects operands and shift.
  - k=0: opA[lo]*opB[lo], shift 0.
  - k=1: opA[hi]*opB[lo], shift HALF_W.
  - k=2: opA[lo]*opB[hi], shift HALF_W.
  - k=3: opA[hi]*opB[hi], shift 2*HALF_W.
  - mul_a and mul_b are driven from opA/opB and k. They are held stable for the whole partial.
  - If cnt < MUL_LAT: cnt increments.
  - If cnt == MUL_LAT: acc += zero-extended mul_p << shift, cnt=0, k increments. After k=3, P <= final acc and state moves to DONE.
  - Each partial takes MUL_LAT+1 cycles.
- DONE: lasts one cycle with done=1 and busy=1. mul_a=mul_b=0. Next state is IDLE.
- Latency: with start accepted at edge e0, done is high during cycle 4*(MUL_LAT+1)+1 after e0. With MUL_LAT=1 this is cycle 9. The next start can be accepted at the edge ending the DONE cycle +1 (i.e. once busy=0).
- start while busy=1 (RUN or DONE) is ignored. It is neither queued nor affects opA/opB.
- A and B may change freely after acceptance.
- Arithmetic:
  - acc is 4*HALF_W bits, unsigned, and cannot overflow.
  - The all-ones case, 0xFFFFFFFF squared, gives 0xFFFFFFFE00000001.
- done is registered (from state), never combinational from inputs.

Optional Feature:
- Macro: VEDIC_SEQ_ZSKIP_EN.
- Defined:
  - On entering a partial in RUN, if the selected opA half or opB half is zero, the partial is skipped.
  - A skip costs exactly 1 cycle: k increments, acc is unchanged, and mul_a=mul_b=0 during that cycle.
  - Non-zero partials behave as above. Latency therefore varies; done/busy remain authoritative.
- Undefined: every partial is issued and latency is always fixed at 4*(MUL_LAT+1)+1.

Test Plan:
- MUL_LAT=1, A=0x00000003, B=0x00000005, 1-cycle start:
  - P=0x000000000000000F with done high exactly 9 cycles after the start edge.
  - busy is high for 9 cycles.
  - mul_a/mul_b sequence is (3,5),(0,5),(3,0),(0,0), two cycles each.
- MUL_LAT=0 and MUL_LAT=3, A=B=0xFFFFFFFF: P=0xFFFFFFFE00000001, with done at cycle 5 and cycle 17 respectively.
- A=0x12345678, B=0x9ABCDEF0, then start pulsed again with A=B=0x1 at cycles 3 and 9: both are ignored and P=0x0B00EA4E242D2080.
- Back-to-back:
  - start is held high continuously with A=0x00010000, B=0x00010000.
  - A second operation begins on the first edge with busy=0.
  - Each result is P=0x0000000100000000, and done pulses are spaced 10 cycles apart (MUL_LAT=1).
- Reset mid-operation: rst=1 in cycle 4 of RUN, then:
  - Next cycle: busy=0, done=0, P=0, mul_a=mul_b=0.
  - A new start then completes normally.
- VEDIC_SEQ_ZSKIP_EN with MUL_LAT=1, A=0x00000003, B=0x00000005:
  - P=0xF with done at cycle 6 (2+1+1+1 RUN cycles + DONE).
  - A=B=0: P=0 with done at cycle 5.
